// File: rtl/mm_bram_arbiter_if.sv
// Signal bundle between the two limb requesters, the BRAM arbiter and the
// single BRAM master port of the Montgomery multiplier subsystem.
interface mm_bram_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 17
);
   logic                  req0_i;
   logic                  we0_i;
   logic [ADDR_WIDTH-1:0] addr0_i;
   logic [DATA_WIDTH-1:0] wdata0_i;
   logic                  gnt0_o;
   logic [DATA_WIDTH-1:0] rdata0_o;
   logic                  rvalid0_o;

   logic                  req1_i;
   logic                  we1_i;
   logic [ADDR_WIDTH-1:0] addr1_i;
   logic [DATA_WIDTH-1:0] wdata1_i;
   logic                  gnt1_o;
   logic [DATA_WIDTH-1:0] rdata1_o;
   logic                  rvalid1_o;

   logic                  BRAM_en_o;
   logic                  BRAM_we_o;
   logic [ADDR_WIDTH-1:0] BRAM_addr_o;
   logic [DATA_WIDTH-1:0] BRAM_din_o;
   logic [DATA_WIDTH-1:0] BRAM_dout_i;

   modport slave (
      input  req0_i, we0_i, addr0_i, wdata0_i,
      output gnt0_o, rdata0_o, rvalid0_o,
      input  req1_i, we1_i, addr1_i, wdata1_i,
      output gnt1_o, rdata1_o, rvalid1_o,
      output BRAM_en_o, BRAM_we_o, BRAM_addr_o, BRAM_din_o,
      input  BRAM_dout_i
   );

   modport master (
      output req0_i, we0_i, addr0_i, wdata0_i,
      input  gnt0_o, rdata0_o, rvalid0_o,
      output req1_i, we1_i, addr1_i, wdata1_i,
      input  gnt1_o, rdata1_o, rvalid1_o,
      input  BRAM_en_o, BRAM_we_o, BRAM_addr_o, BRAM_din_o,
      output BRAM_dout_i
   );
endinterface

// File: rtl/mm_bram_arbiter.sv
// Round-robin arbiter with bounded burst locking between the MM core (0) and
// the operand loader (1), with a tagged, latency-matched read return path.
module mm_bram_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 17,
   parameter int RD_LATENCY = 1,
   parameter int MAX_BURST  = 8
) (
   input  logic             clock_i,
   input  logic             reset_n_i,
   mm_bram_arbiter_if.slave bus
);
   localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

   typedef struct packed {
      logic valid;
      logic id;
   } ret_tag_t;

   logic                  gnt0_s;
   logic                  gnt1_s;
   logic                  burst_lock_s;
   logic                  read_acc_s;
   logic                  last_owner_r;
   logic [7:0]            burst_cnt_r;
   logic                  bram_we_s;
   logic [ADDR_WIDTH-1:0] bram_addr_s;
   logic [DATA_WIDTH-1:0] bram_din_s;
   ret_tag_t              ret_pipe_r [RD_LATENCY];
   ret_tag_t              ret_tail_s;
   logic                  rvalid0_s;
   logic                  rvalid1_s;
   logic [DATA_WIDTH-1:0] rdata0_r;
   logic [DATA_WIDTH-1:0] rdata1_r;

   // The current owner keeps the port while its run is active but not yet at the limit.
   assign burst_lock_s = (burst_cnt_r != 8'd0) && (burst_cnt_r < MAX_CNT);

   // Grant decision from live requests and the registered owner/run state.
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (!reset_n_i) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (bus.req0_i && !bus.req1_i) begin
         gnt0_s = 1'b1;
      end else if (!bus.req0_i && bus.req1_i) begin
         gnt1_s = 1'b1;
      end else if (bus.req0_i && bus.req1_i) begin
         if (burst_lock_s) begin
            gnt0_s = ~last_owner_r;
            gnt1_s = last_owner_r;
         end else begin
            gnt0_s = last_owner_r;
            gnt1_s = ~last_owner_r;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Steer the granted requester onto the BRAM port; idle cycles drive zeros.
   always_comb begin
      bram_we_s   = 1'b0;
      bram_addr_s = '0;
      bram_din_s  = '0;
      if (gnt0_s) begin
         bram_we_s   = bus.we0_i;
         bram_addr_s = bus.addr0_i;
         bram_din_s  = bus.wdata0_i;
      end else if (gnt1_s) begin
         bram_we_s   = bus.we1_i;
         bram_addr_s = bus.addr1_i;
         bram_din_s  = bus.wdata1_i;
      end else begin
         bram_we_s   = 1'b0;
         bram_addr_s = '0;
         bram_din_s  = '0;
      end
   end

   // Owner pointer and saturating run-length counter.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_owner_r <= 1'b1;
         burst_cnt_r  <= 8'd0;
      end else if (gnt0_s || gnt1_s) begin
         if (gnt1_s == last_owner_r) begin
            burst_cnt_r <= (burst_cnt_r < MAX_CNT) ? (burst_cnt_r + 8'd1) : MAX_CNT;
         end else begin
            burst_cnt_r  <= 8'd1;
            last_owner_r <= gnt1_s;
         end
      end else begin
         burst_cnt_r <= 8'd0;
      end
   end

   assign read_acc_s = (gnt0_s && !bus.we0_i) || (gnt1_s && !bus.we1_i);

   // Return tags travel alongside the BRAM read latency; reset discards in-flight reads.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            ret_pipe_r[i] <= '0;
         end
      end else begin
         ret_pipe_r[0] <= '{valid: read_acc_s, id: gnt1_s};
         for (int i = 1; i < RD_LATENCY; i++) begin
            ret_pipe_r[i] <= ret_pipe_r[i-1];
         end
      end
   end

   assign ret_tail_s = ret_pipe_r[RD_LATENCY-1];
   assign rvalid0_s  = ret_tail_s.valid && !ret_tail_s.id;
   assign rvalid1_s  = ret_tail_s.valid && ret_tail_s.id;

   // Hold the last returned word per requester between returns.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rdata0_r <= '0;
         rdata1_r <= '0;
      end else begin
         if (rvalid0_s) begin
            rdata0_r <= bus.BRAM_dout_i;
         end
         if (rvalid1_s) begin
            rdata1_r <= bus.BRAM_dout_i;
         end
      end
   end

   assign bus.gnt0_o      = gnt0_s;
   assign bus.gnt1_o      = gnt1_s;
   assign bus.rvalid0_o   = rvalid0_s;
   assign bus.rvalid1_o   = rvalid1_s;
   assign bus.rdata0_o    = rvalid0_s ? bus.BRAM_dout_i : rdata0_r;
   assign bus.rdata1_o    = rvalid1_s ? bus.BRAM_dout_i : rdata1_r;
   assign bus.BRAM_en_o   = gnt0_s | gnt1_s;
   assign bus.BRAM_we_o   = bram_we_s;
   assign bus.BRAM_addr_o = bram_addr_s;
   assign bus.BRAM_din_o  = bram_din_s;
endmodule

// File: tb/tb_mm_bram_arbiter.sv
// Bench for mm_bram_arbiter: two instances (read latency 1 and 3) share the
// same requester stimulus and are checked every cycle against a request-level model.
module tb_mm_bram_arbiter;
   localparam int MAXB = 8;

   typedef struct {
      int          inst;
      int          due;
      bit          id;
      logic [16:0] data;
   } ret_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, addr1;
   logic [16:0] wdata0, wdata1;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;

   logic        gnt0_a [2];
   logic        gnt1_a [2];
   logic        rv0_a  [2];
   logic        rv1_a  [2];
   logic [16:0] rd0_a  [2];
   logic [16:0] rd1_a  [2];
   logic        ben_a  [2];
   logic        bwe_a  [2];
   logic [31:0] baddr_a[2];
   logic [16:0] bdin_a [2];

   logic [16:0] mem     [2][256];
   bit          written [2][256];
   logic [16:0] dq1;
   logic [16:0] dq3 [3];

   bit          last_m    [2];
   int          run_m     [2];
   logic [16:0] lastrd0_m [2];
   logic [16:0] lastrd1_m [2];
   ret_t        ret_q [$];

   int cnt_a [2];
   int cnt_b [2];

   mm_bram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(17)) i1 ();
   mm_bram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(17)) i3 ();

   mm_bram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(17), .RD_LATENCY(1), .MAX_BURST(MAXB)) dut1 (
      .clock_i(clk), .reset_n_i(rst_n), .bus(i1));
   mm_bram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(17), .RD_LATENCY(3), .MAX_BURST(MAXB)) dut3 (
      .clock_i(clk), .reset_n_i(rst_n), .bus(i3));

   always #5 clk = ~clk;

   assign i1.req0_i = req0;   assign i3.req0_i = req0;
   assign i1.we0_i = we0;     assign i3.we0_i = we0;
   assign i1.addr0_i = addr0; assign i3.addr0_i = addr0;
   assign i1.wdata0_i = wdata0; assign i3.wdata0_i = wdata0;
   assign i1.req1_i = req1;   assign i3.req1_i = req1;
   assign i1.we1_i = we1;     assign i3.we1_i = we1;
   assign i1.addr1_i = addr1; assign i3.addr1_i = addr1;
   assign i1.wdata1_i = wdata1; assign i3.wdata1_i = wdata1;
   assign i1.BRAM_dout_i = dq1;
   assign i3.BRAM_dout_i = dq3[2];

   assign gnt0_a[0] = i1.gnt0_o;      assign gnt0_a[1] = i3.gnt0_o;
   assign gnt1_a[0] = i1.gnt1_o;      assign gnt1_a[1] = i3.gnt1_o;
   assign rv0_a[0] = i1.rvalid0_o;    assign rv0_a[1] = i3.rvalid0_o;
   assign rv1_a[0] = i1.rvalid1_o;    assign rv1_a[1] = i3.rvalid1_o;
   assign rd0_a[0] = i1.rdata0_o;     assign rd0_a[1] = i3.rdata0_o;
   assign rd1_a[0] = i1.rdata1_o;     assign rd1_a[1] = i3.rdata1_o;
   assign ben_a[0] = i1.BRAM_en_o;    assign ben_a[1] = i3.BRAM_en_o;
   assign bwe_a[0] = i1.BRAM_we_o;    assign bwe_a[1] = i3.BRAM_we_o;
   assign baddr_a[0] = i1.BRAM_addr_o; assign baddr_a[1] = i3.BRAM_addr_o;
   assign bdin_a[0] = i1.BRAM_din_o;  assign bdin_a[1] = i3.BRAM_din_o;

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   // Unwritten words read back as 0x10000 | low address byte.
   function automatic logic [16:0] mem_rd(input int k, input logic [31:0] a);
      logic [7:0] ix;
      ix = a[7:0];
      return written[k][ix] ? mem[k][ix] : (17'h10000 | {9'd0, ix});
   endfunction

   // Write-first BRAM models behind each instance.
   always @(posedge clk) begin
      if (ben_a[0]) begin
         if (bwe_a[0]) begin
            mem[0][baddr_a[0][7:0]]     <= bdin_a[0];
            written[0][baddr_a[0][7:0]] <= 1'b1;
         end
         dq1 <= bwe_a[0] ? bdin_a[0] : mem_rd(0, baddr_a[0]);
      end
      if (ben_a[1]) begin
         if (bwe_a[1]) begin
            mem[1][baddr_a[1][7:0]]     <= bdin_a[1];
            written[1][baddr_a[1][7:0]] <= 1'b1;
         end
         dq3[0] <= bwe_a[1] ? bdin_a[1] : mem_rd(1, baddr_a[1]);
      end
      dq3[1] <= dq3[0];
      dq3[2] <= dq3[1];
   end

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lat%0d actual=%0h expected=%0h (cycle %0d)", name, lat(k), act, exp, cyc_n);
      end
   endtask

   // Per-cycle comparison against the arbitration rules and the return queue.
   task automatic model_step();
      bit          has_g, g, e_we, rv0, rv1;
      logic [31:0] e_addr;
      logic [16:0] e_din;
      int          idx;
      cyc_n++;
      for (int k = 0; k < 2; k++) begin
         has_g = 1'b0; g = 1'b0; e_we = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
         e_addr = 32'd0; e_din = 17'd0;
         if (!rst_n) begin
            last_m[k] = 1'b1; run_m[k] = 0;
            lastrd0_m[k] = 17'd0; lastrd1_m[k] = 17'd0;
            for (int i = ret_q.size() - 1; i >= 0; i--) begin
               if (ret_q[i].inst == k) ret_q.delete(i);
            end
         end else begin
            if (req0 && req1) begin
               has_g = 1'b1;
               g = (run_m[k] > 0 && run_m[k] < MAXB) ? last_m[k] : !last_m[k];
            end else if (req0) begin
               has_g = 1'b1; g = 1'b0;
            end else if (req1) begin
               has_g = 1'b1; g = 1'b1;
            end
            if (has_g) begin
               e_we   = g ? we1 : we0;
               e_addr = g ? addr1 : addr0;
               e_din  = g ? wdata1 : wdata0;
            end
            idx = -1;
            for (int i = 0; i < ret_q.size(); i++) begin
               if (ret_q[i].inst == k && ret_q[i].due == cyc_n) idx = i;
            end
            if (idx >= 0) begin
               if (ret_q[idx].id) begin
                  rv1 = 1'b1; lastrd1_m[k] = ret_q[idx].data;
               end else begin
                  rv0 = 1'b1; lastrd0_m[k] = ret_q[idx].data;
               end
               ret_q.delete(idx);
            end
         end
         chk("gnt0", k, 32'(gnt0_a[k]), 32'(has_g && !g));
         chk("gnt1", k, 32'(gnt1_a[k]), 32'(has_g && g));
         chk("bram_en", k, 32'(ben_a[k]), 32'(has_g));
         chk("bram_we", k, 32'(bwe_a[k]), 32'(e_we));
         chk("bram_addr", k, baddr_a[k], e_addr);
         chk("bram_din", k, 32'(bdin_a[k]), 32'(e_din));
         chk("rvalid0", k, 32'(rv0_a[k]), 32'(rv0));
         chk("rvalid1", k, 32'(rv1_a[k]), 32'(rv1));
         chk("rdata0", k, 32'(rd0_a[k]), 32'(lastrd0_m[k]));
         chk("rdata1", k, 32'(rd1_a[k]), 32'(lastrd1_m[k]));
         if (rst_n) begin
            if (has_g) begin
               run_m[k]  = (g == last_m[k]) ? ((run_m[k] < MAXB) ? run_m[k] + 1 : MAXB) : 1;
               last_m[k] = g;
               if (!e_we) ret_q.push_back('{inst: k, due: cyc_n + lat(k), id: g, data: mem_rd(k, e_addr)});
            end else begin
               run_m[k] = 0;
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         adv();
      end
   endtask

   task automatic drv(input bit r0, input bit w0, input logic [31:0] a0, input logic [16:0] d0,
                      input bit r1, input bit w1, input logic [31:0] a1, input logic [16:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   initial begin
      rst_n = 1'b0;
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(2);
      rst_n = 1'b1;

      // Idle after reset, then a single core read of 0x10.
      tick();
      for (int k = 0; k < 2; k++) chk("idle_en", k, 32'(ben_a[k]), 32'd0);
      adv();
      drv(1'b1, 1'b0, 32'h10, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      tick();
      for (int k = 0; k < 2; k++) chk("t1_gnt0", k, 32'(gnt0_a[k]), 32'd1);
      adv();
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      tick();
      chk("t1_rvalid0", 0, 32'(rv0_a[0]), 32'd1);
      chk("t1_rdata0", 0, 32'(rd0_a[0]), 32'h10010);
      chk("t1_rvalid1", 0, 32'(rv1_a[0]), 32'd0);
      adv();
      step(1);
      tick();
      chk("t1_rvalid0", 1, 32'(rv0_a[1]), 32'd1);
      chk("t1_rdata0", 1, 32'(rd0_a[1]), 32'h10010);
      adv();

      // Both requesters continuously from reset: 8/8 alternating bursts.
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      drv(1'b1, 1'b0, 32'h20, 17'd0, 1'b1, 1'b0, 32'h30, 17'd0);
      for (int k = 0; k < 2; k++) begin cnt_a[k] = 0; cnt_b[k] = 0; end
      for (int i = 0; i < 32; i++) begin
         tick();
         for (int k = 0; k < 2; k++) begin
            chk("burst_owner", k, 32'(gnt1_a[k]), 32'((i / 8) % 2));
            cnt_a[k] += int'(gnt0_a[k]);
            cnt_b[k] += int'(gnt1_a[k]);
         end
         adv();
      end
      for (int k = 0; k < 2; k++) begin
         chk("burst_gnt0_total", k, 32'(cnt_a[k]), 32'd16);
         chk("burst_gnt1_total", k, 32'(cnt_b[k]), 32'd16);
      end
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(4);

      // Loader writes 0x1ABCD to 5, core reads it back.
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b1, 1'b1, 32'd5, 17'h1ABCD);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("wr_we", k, 32'(bwe_a[k]), 32'd1);
         chk("wr_din", k, 32'(bdin_a[k]), 32'h1ABCD);
         chk("wr_addr", k, baddr_a[k], 32'd5);
      end
      adv();
      drv(1'b1, 1'b0, 32'd5, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      tick();
      for (int k = 0; k < 2; k++) chk("wr_no_rvalid", k, 32'(rv0_a[k] | rv1_a[k]), 32'd0);
      adv();
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      tick();
      chk("raw_rdata0", 0, 32'(rd0_a[0]), 32'h1ABCD);
      adv();
      step(1);
      tick();
      chk("raw_rdata0", 1, 32'(rd0_a[1]), 32'h1ABCD);
      adv();

      // Alternating reads core@1, loader@2, core@3.
      drv(1'b1, 1'b0, 32'd1, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(1);
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b1, 1'b0, 32'd2, 17'd0);
      step(1);
      drv(1'b1, 1'b0, 32'd3, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(1);
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      tick();
      chk("alt_rv0_a", 1, 32'(rv0_a[1]), 32'd1);
      chk("alt_rd0_a", 1, 32'(rd0_a[1]), 32'h10001);
      adv();
      tick();
      chk("alt_rv1_b", 1, 32'(rv1_a[1]), 32'd1);
      chk("alt_rd1_b", 1, 32'(rd1_a[1]), 32'h10002);
      adv();
      tick();
      chk("alt_rv0_c", 1, 32'(rv0_a[1]), 32'd1);
      chk("alt_rd0_c", 1, 32'(rd0_a[1]), 32'h10003);
      adv();

      // Reset one cycle after two reads are accepted.
      drv(1'b1, 1'b0, 32'd7, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(1);
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b1, 1'b0, 32'd8, 17'd0);
      step(1);
      rst_n = 1'b0;
      drv(1'b1, 1'b1, 32'h40, 17'h00555, 1'b1, 1'b1, 32'h41, 17'h00AAA);
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("rst_gnt", k, 32'(gnt0_a[k] | gnt1_a[k]), 32'd0);
         chk("rst_en", k, 32'(ben_a[k]), 32'd0);
         chk("rst_rvalid", k, 32'(rv0_a[k] | rv1_a[k]), 32'd0);
         chk("rst_rdata0", k, 32'(rd0_a[k]), 32'd0);
      end
      adv();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk("post_rst_gnt0", k, 32'(gnt0_a[k]), 32'd1);
         chk("post_rst_gnt1", k, 32'(gnt1_a[k]), 32'd0);
      end
      adv();
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      for (int k = 0; k < 2; k++) cnt_a[k] = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         for (int k = 0; k < 2; k++) cnt_a[k] += int'(rv0_a[k] | rv1_a[k]);
         adv();
      end
      for (int k = 0; k < 2; k++) chk("post_rst_no_rvalid", k, 32'(cnt_a[k]), 32'd0);

      // Lone loader for 20 cycles, then the core joins with the counter saturated.
      for (int k = 0; k < 2; k++) cnt_b[k] = 0;
      for (int i = 0; i < 20; i++) begin
         drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b1, 1'b0, 32'(i), 17'd0);
         tick();
         for (int k = 0; k < 2; k++) cnt_b[k] += int'(gnt1_a[k]);
         adv();
      end
      for (int k = 0; k < 2; k++) chk("solo_gnt1_total", k, 32'(cnt_b[k]), 32'd20);
      drv(1'b1, 1'b0, 32'h50, 17'd0, 1'b1, 1'b0, 32'h51, 17'd0);
      tick();
      for (int k = 0; k < 2; k++) chk("sat_handover_gnt0", k, 32'(gnt0_a[k]), 32'd1);
      adv();
      drv(1'b0, 1'b0, 32'd0, 17'd0, 1'b0, 1'b0, 32'd0, 17'd0);
      step(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mm_bram_arbiter.md
Name: mm_bram_arbiter

Overview:
- Shares the single 17-bit-data BRAM master port of the Montgomery multiplier subsystem between two requesters.
- Requester 0 is the MM core. Requester 1 is the operand loader/readback engine that writes A, B, N and reads results.
- Round-robin arbitration with bounded burst locking, so the core can stream consecutive limbs without starving the loader.
- Returns read data to the originating requester through a latency-matched, tagged return pipeline.

Parameters:
ADDR_WIDTH, 32, word address width (the wrapper shifts the address left by 2 downstream).
DATA_WIDTH, 17, limb width.
RD_LATENCY, 1, BRAM read latency in cycles (1..4).
MAX_BURST, 8, maximum consecutive grants to one requester while the other is waiting (1..255).

Ports:
clock_i  in  1  system clock, rising edge.
reset_n_i  in  1  asynchronous active-low reset.
req0_i  in  1  core access request, held until granted.
we0_i  in  1  core write (1) / read (0).
addr0_i  in  ADDR_WIDTH  core word address.
wdata0_i  in  DATA_WIDTH  core write data.
gnt0_o  out  1  core access accepted this cycle.
rdata0_o  out  DATA_WIDTH  read data returned to the core.
rvalid0_o  out  1  rdata0_o valid.
req1_i, we1_i, addr1_i, wdata1_i  in  1/1/ADDR_WIDTH/DATA_WIDTH  loader equivalents.
gnt1_o, rdata1_o, rvalid1_o  out  1/DATA_WIDTH/1  loader equivalents.
BRAM_en_o  out  1  BRAM enable.
BRAM_we_o  out  1  BRAM write enable.
BRAM_addr_o  out  ADDR_WIDTH  BRAM word address.
BRAM_din_o  out  DATA_WIDTH  BRAM write data.
BRAM_dout_i  in  DATA_WIDTH  BRAM read data.

Behaviour:
- Reset values: all gnt/rvalid/BRAM_en/BRAM_we outputs 0, rdata 0, BRAM_addr/din 0, last-owner pointer = 1 (requester 0 wins the first tie), burst counter 0, return pipeline cleared.
- Reset is asynchronous assert; deassertion is sampled on clock_i.
- Reset mid-operation drops in-flight reads: no rvalid is ever issued for accesses accepted before reset.
- Grant is combinational from the current req_i values and registered state:
  - Only one req high: that requester is granted.
  - Both high, burst counter < MAX_BURST and owner == last owner: owner keeps the grant (burst lock).
  - Both high, counter reached MAX_BURST: grant goes to the other requester.
  - Both high, no current lock: grant goes to the requester not granted last.
  - Neither high: no grant, BRAM_en_o = 0.
- Exactly one gnt is high per cycle at most; a gnt is never high without its req.
- BRAM_en_o = gnt0|gnt1. BRAM_we/addr/din are muxed combinationally from the granted requester. Ungranted cycles drive addr/din to 0 and we to 0.
- A request is accepted on the rising edge where req & gnt; the requester drops or advances its request on the next cycle.
- Burst counter:
  - Increments on each grant to the same owner.
  - Loads 1 on an owner change.
  - Clears to 0 on an idle cycle or when the owner drops req.
  - Saturates at MAX_BURST.
- Return pipeline: an RD_LATENCY-deep shift register of {valid, id}. It is loaded with valid = grant & ~we.
  - At the tail, rvalidX_o pulses for one cycle with rdataX_o = BRAM_dout_i (combinational pass-through, registered only via the pipeline tag).
  - rdataX_o holds its last value otherwise.
- Write accesses produce no rvalid.
- Back-to-back reads from alternating requesters return in issue order, one per cycle, with no bubbles.
- Same-cycle write by one requester and read by the other is impossible (single grant); the loser retries next cycle.
- Read-after-write to the same address in consecutive cycles returns the written data (BRAM read-first/write-first semantics are outside this block's scope; the bench uses a write-first model).

Test Plan:
- Reset then idle: all outputs 0. req0_i=1 read addr 0x10 with RD_LATENCY=1 -> gnt0_o=1 that cycle; rvalid0_o=1 next cycle with the model data at 0x10; rvalid1_o stays 0.
- Both requesters request continuously from reset, MAX_BURST=8 -> core granted 8 cycles, loader 8, alternating. Each requester gets exactly 16 grants over 32 cycles.
- Loader writes 0x1ABCD to addr 5 (BRAM_we_o=1, din=0x1ABCD, addr=5), then core reads addr 5 -> rvalid0_o with rdata0_o=0x1ABCD. No rvalid during the write.
- RD_LATENCY=3, alternating reads core@1, loader@2, core@3 -> rvalid0, rvalid1, rvalid0 on cycles +3, +4, +5, each with the matching data.
- reset_n_i pulled low one cycle after two reads are accepted -> outputs clear immediately. No rvalid appears after release. The next request is granted normally, with the core winning the tie.
- Single requester, req held 20 cycles, other idle -> continuous grant with no forced handover despite the counter saturating at MAX_BURST.
